// File: rtl/soundweb_stream_encoder.sv
// Byte-stream framer for SoundWeb messages: STX, escaped body, optional escaped
// XOR checksum, ETX, with valid/ready flow control on both sides.
module soundweb_stream_encoder #(
    parameter int DATA_BYTES = 4,
    parameter bit CSUM_EN    = 1'b1
) (
    input  logic                    clk,
    input  logic                    reset_n,
    input  logic                    in_valid,
    output logic                    in_ready,
    input  logic [7:0]              in_command,
    input  logic [47:0]             in_address,
    input  logic [15:0]             in_sv,
    input  logic [8*DATA_BYTES-1:0] in_data,
    output logic                    out_valid,
    input  logic                    out_ready,
    output logic [7:0]              out_byte,
    output logic                    out_sop,
    output logic                    out_eop,
    output logic                    busy,
    output logic [15:0]             pkt_count
);

    // state    | meaning
    // IDLE     | waiting for a message, in_ready=1
    // STX      | 0x02 on out_byte
    // BODY     | raw byte (or its 0x1B escape prefix) on out_byte
    // ESC      | escaped raw byte (r+0x80) on out_byte
    // CSUM     | checksum (or its 0x1B escape prefix) on out_byte
    // CSUM_ESC | escaped checksum on out_byte
    // ETX      | 0x03 on out_byte
    typedef enum logic [2:0] {
        S_IDLE,
        S_STX,
        S_BODY,
        S_ESC,
        S_CSUM,
        S_CSUM_ESC,
        S_ETX
    } state_t;

    localparam int NRAW  = 9 + DATA_BYTES;
    localparam int RAW_W = 8 * NRAW;
    localparam int IDX_W = 5;

    state_t           state;
    logic [RAW_W-1:0] raw_q;
    logic [IDX_W-1:0] idx;
    logic [7:0]       csum;

    logic [7:0] raw_cur;
    logic [7:0] raw_next;
    logic [7:0] csum_nxt;
    logic       last_byte;
    state_t     adv_state;
    logic [7:0] adv_byte;

    function automatic logic needs_esc(input logic [7:0] b);
        return (b == 8'h02) || (b == 8'h03) || (b == 8'h06) ||
               (b == 8'h15) || (b == 8'h1B);
    endfunction

    // Raw bytes are kept in a shift register so the current byte is always the low byte.
    assign raw_cur   = raw_q[7:0];
    assign raw_next  = raw_q[15:8];
    assign csum_nxt  = csum ^ raw_cur;
    assign last_byte = (idx == IDX_W'(NRAW - 1));

    assign in_ready  = (state == S_IDLE);
    assign busy      = (state != S_IDLE);

    // What goes on the wire once the current raw byte has been fully sent.
    always_comb begin
        adv_state = S_BODY;
        adv_byte  = needs_esc(raw_next) ? 8'h1B : raw_next;
        if (last_byte) begin
            if (CSUM_EN) begin
                adv_state = S_CSUM;
                adv_byte  = needs_esc(csum_nxt) ? 8'h1B : csum_nxt;
            end else begin
                adv_state = S_ETX;
                adv_byte  = 8'h03;
            end
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state     <= S_IDLE;
            raw_q     <= '0;
            idx       <= '0;
            csum      <= 8'h00;
            out_valid <= 1'b0;
            out_byte  <= 8'h00;
            out_sop   <= 1'b0;
            out_eop   <= 1'b0;
            pkt_count <= 16'h0000;
        end else begin
            unique case (state)
                S_IDLE: begin
                    if (in_valid) begin
                        raw_q     <= {in_data, in_sv, in_address, in_command};
                        idx       <= '0;
                        csum      <= 8'h00;
                        state     <= S_STX;
                        out_valid <= 1'b1;
                        out_byte  <= 8'h02;
                        out_sop   <= 1'b1;
                        out_eop   <= 1'b0;
                    end
                end
                S_STX: begin
                    if (out_ready) begin
                        state    <= S_BODY;
                        out_sop  <= 1'b0;
                        out_byte <= needs_esc(raw_cur) ? 8'h1B : raw_cur;
                    end
                end
                S_BODY, S_ESC: begin
                    if (out_ready) begin
                        if (state == S_BODY && needs_esc(raw_cur)) begin
                            state    <= S_ESC;
                            out_byte <= raw_cur + 8'h80;
                        end else begin
                            csum     <= csum_nxt;
                            raw_q    <= {8'h00, raw_q[RAW_W-1:8]};
                            idx      <= idx + 1'b1;
                            state    <= adv_state;
                            out_byte <= adv_byte;
                            out_eop  <= (adv_state == S_ETX);
                        end
                    end
                end
                S_CSUM: begin
                    if (out_ready) begin
                        if (needs_esc(csum)) begin
                            state    <= S_CSUM_ESC;
                            out_byte <= csum + 8'h80;
                        end else begin
                            state    <= S_ETX;
                            out_byte <= 8'h03;
                            out_eop  <= 1'b1;
                        end
                    end
                end
                S_CSUM_ESC: begin
                    if (out_ready) begin
                        state    <= S_ETX;
                        out_byte <= 8'h03;
                        out_eop  <= 1'b1;
                    end
                end
                S_ETX: begin
                    if (out_ready) begin
                        state     <= S_IDLE;
                        out_valid <= 1'b0;
                        out_byte  <= 8'h00;
                        out_eop   <= 1'b0;
                        idx       <= '0;
                        pkt_count <= pkt_count + 16'h0001;
                    end
                end
                default: begin
                    state     <= S_IDLE;
                    out_valid <= 1'b0;
                    out_sop   <= 1'b0;
                    out_eop   <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_soundweb_stream_encoder.sv
// Bench for soundweb_stream_encoder: directed frames plus randomized messages
// compared against a frame-level reference model.
module tb_soundweb_stream_encoder;

    logic        clk;
    logic        reset_n;

    logic        in_valid;
    logic        in_ready;
    logic [7:0]  in_command;
    logic [47:0] in_address;
    logic [15:0] in_sv;
    logic [31:0] in_data;
    logic        out_valid;
    logic        out_ready;
    logic [7:0]  out_byte;
    logic        out_sop;
    logic        out_eop;
    logic        busy;
    logic [15:0] pkt_count;

    logic        in_valid2;
    logic        in_ready2;
    logic [7:0]  in_command2;
    logic [47:0] in_address2;
    logic [15:0] in_sv2;
    logic [15:0] in_data2;
    logic        out_valid2;
    logic        out_ready2;
    logic [7:0]  out_byte2;
    logic        out_sop2;
    logic        out_eop2;
    logic        busy2;
    logic [15:0] pkt_count2;

    soundweb_stream_encoder #(.DATA_BYTES(4), .CSUM_EN(1'b1)) dut (
        .clk(clk), .reset_n(reset_n),
        .in_valid(in_valid), .in_ready(in_ready), .in_command(in_command),
        .in_address(in_address), .in_sv(in_sv), .in_data(in_data),
        .out_valid(out_valid), .out_ready(out_ready), .out_byte(out_byte),
        .out_sop(out_sop), .out_eop(out_eop), .busy(busy), .pkt_count(pkt_count)
    );

    soundweb_stream_encoder #(.DATA_BYTES(2), .CSUM_EN(1'b0)) dut2 (
        .clk(clk), .reset_n(reset_n),
        .in_valid(in_valid2), .in_ready(in_ready2), .in_command(in_command2),
        .in_address(in_address2), .in_sv(in_sv2), .in_data(in_data2),
        .out_valid(out_valid2), .out_ready(out_ready2), .out_byte(out_byte2),
        .out_sop(out_sop2), .out_eop(out_eop2), .busy(busy2), .pkt_count(pkt_count2)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int          n_vec = 0;
    int          n_err = 0;
    int          cyc = 0;
    int          frames_done = 0;
    int          frames2_done = 0;
    int          eop_cyc = 0;
    int          acc_cyc = 0;
    int          rdy_mode = 0;
    int          rdy_phase = 0;
    logic [15:0] exp_cnt = 16'h0000;
    logic [9:0]  exp_q[$];
    logic [9:0]  got_q[$];
    logic [9:0]  got2_q[$];
    logic        stall = 1'b0;
    logic [9:0]  hold = '0;

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    // Reference model: frame = {sop,eop,byte} entries built from the message fields.
    task automatic push_esc(input logic [7:0] r);
        if (r == 8'h02 || r == 8'h03 || r == 8'h06 || r == 8'h15 || r == 8'h1B) begin
            exp_q.push_back({2'b00, 8'h1B});
            exp_q.push_back({2'b00, r + 8'h80});
        end else begin
            exp_q.push_back({2'b00, r});
        end
    endtask

    task automatic build_exp(input logic [7:0] c, input logic [47:0] a, input logic [15:0] s,
                             input logic [63:0] d, input int nd, input bit ce);
        logic [7:0] raw[$];
        logic [7:0] x;
        x = 8'h00;
        raw.push_back(c);
        for (int i = 0; i < 6; i++) raw.push_back(a[8*i +: 8]);
        for (int i = 0; i < 2; i++) raw.push_back(s[8*i +: 8]);
        for (int i = 0; i < nd; i++) raw.push_back(d[8*i +: 8]);
        exp_q.push_back({2'b10, 8'h02});
        foreach (raw[i]) begin
            x = x ^ raw[i];
            push_esc(raw[i]);
        end
        if (ce) push_esc(x);
        exp_q.push_back({2'b01, 8'h03});
    endtask

    task automatic compare_frame(input string tag);
        check_val($sformatf("%s_len", tag), 32'(got_q.size()), 32'(exp_q.size()));
        for (int i = 0; i < exp_q.size() && i < got_q.size(); i++)
            check_val($sformatf("%s_b%0d", tag, i), 32'(got_q[i]), 32'(exp_q[i]));
        got_q.delete();
        exp_q.delete();
    endtask

    function automatic logic [7:0] rand_byte();
        if ($urandom_range(0, 2) == 0) begin
            case ($urandom_range(0, 4))
                0: return 8'h02;
                1: return 8'h03;
                2: return 8'h06;
                3: return 8'h15;
                default: return 8'h1B;
            endcase
        end
        return 8'($urandom);
    endfunction

    always @(posedge clk) cyc <= cyc + 1;

    initial begin
        out_ready = 1'b1;
        forever begin
            @(posedge clk);
            #1;
            case (rdy_mode)
                1: begin
                    out_ready = (rdy_phase == 0);
                    rdy_phase = (rdy_phase + 1) % 3;
                end
                2: out_ready = ($urandom_range(0, 3) != 0);
                default: out_ready = 1'b1;
            endcase
        end
    end

    always @(negedge clk) begin
        if (!reset_n) begin
            stall = 1'b0;
        end else begin
            if (stall)
                check_val("stall_hold", 32'({out_valid, out_sop, out_eop, out_byte}), 32'({1'b1, hold}));
            if (out_valid && out_ready) begin
                got_q.push_back({out_sop, out_eop, out_byte});
                if (out_eop) begin
                    frames_done++;
                    eop_cyc = cyc + 1;
                end
            end
            stall = out_valid && !out_ready;
            hold  = {out_sop, out_eop, out_byte};
        end
    end

    always @(negedge clk) begin
        if (reset_n && out_valid2 && out_ready2) begin
            got2_q.push_back({out_sop2, out_eop2, out_byte2});
            if (out_eop2) frames2_done++;
        end
    end

    task automatic offer(input logic [7:0] c, input logic [47:0] a, input logic [15:0] s,
                         input logic [31:0] d);
        int t;
        @(posedge clk);
        #1;
        in_command = c;
        in_address = a;
        in_sv      = s;
        in_data    = d;
        in_valid   = 1'b1;
        t = 0;
        @(negedge clk);
        while (!in_ready && t < 3000) begin
            @(negedge clk);
            t++;
        end
        check_val("accept_seen", 32'(t < 3000), 32'd1);
        acc_cyc = cyc + 1;
        @(posedge clk);
        #1;
        in_valid   = 1'b0;
        in_command = 8'($urandom);
        in_address = {16'($urandom), $urandom};
        in_sv      = 16'($urandom);
        in_data    = $urandom;
        check_val("stx_valid", 32'(out_valid), 32'd1);
        check_val("stx_byte", 32'(out_byte), 32'h02);
        check_val("stx_sop", 32'(out_sop), 32'd1);
        check_val("stx_busy", 32'(busy), 32'd1);
        check_val("stx_in_ready", 32'(in_ready), 32'd0);
    endtask

    task automatic wait_frames(input int target);
        int t;
        t = 0;
        while (frames_done < target && t < 3000) begin
            @(negedge clk);
            t++;
        end
        check_val("frame_done", 32'(frames_done), 32'(target));
        @(posedge clk);
        #1;
    endtask

    initial begin
        logic [7:0]  c;
        logic [47:0] a;
        logic [15:0] s;
        logic [31:0] d;
        int          t;

        reset_n = 1'b0;
        in_valid = 1'b0; in_command = '0; in_address = '0; in_sv = '0; in_data = '0;
        in_valid2 = 1'b0; in_command2 = '0; in_address2 = '0; in_sv2 = '0; in_data2 = '0;
        out_ready2 = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        check_val("rst_in_ready", 32'(in_ready), 32'd1);
        check_val("rst_out_valid", 32'(out_valid), 32'd0);
        check_val("rst_out_byte", 32'(out_byte), 32'h00);
        check_val("rst_sop_eop", 32'({out_sop, out_eop}), 32'd0);
        check_val("rst_busy", 32'(busy), 32'd0);
        check_val("rst_pkt_count", 32'(pkt_count), 32'd0);
        reset_n = 1'b1;

        // Nominal frame.
        rdy_mode = 0;
        build_exp(8'h88, 48'h0, 16'h0, 64'h1, 4, 1'b1);
        offer(8'h88, 48'h0, 16'h0, 32'h1);
        wait_frames(1);
        check_val("nominal_len16", 32'(got_q.size()), 32'd16);
        compare_frame("nominal");
        exp_cnt = exp_cnt + 16'h1;
        check_val("nominal_pkt", 32'(pkt_count), 32'(exp_cnt));

        // Escaped command and checksum.
        build_exp(8'h02, 48'h0, 16'h0, 64'h0, 4, 1'b1);
        offer(8'h02, 48'h0, 16'h0, 32'h0);
        wait_frames(2);
        check_val("esc_len18", 32'(got_q.size()), 32'd18);
        compare_frame("esc");
        exp_cnt = exp_cnt + 16'h1;

        // Backpressure 1,0,0 pattern.
        rdy_mode = 1;
        rdy_phase = 0;
        build_exp(8'h88, 48'h0, 16'h0, 64'h1, 4, 1'b1);
        offer(8'h88, 48'h0, 16'h0, 32'h1);
        wait_frames(3);
        compare_frame("bp");
        exp_cnt = exp_cnt + 16'h1;
        check_val("bp_pkt", 32'(pkt_count), 32'(exp_cnt));

        // Back-to-back: second message waits while busy, accepted right after ETX.
        rdy_mode = 0;
        build_exp(8'h15, 48'h0102_0304_0506, 16'h1B03, 64'h0000_0000_0600_1B02, 4, 1'b1);
        build_exp(8'h41, 48'hA5A5_0000_FFFF, 16'h1234, 64'h0000_0000_DEAD_BEEF, 4, 1'b1);
        offer(8'h15, 48'h0102_0304_0506, 16'h1B03, 32'h0600_1B02);
        offer(8'h41, 48'hA5A5_0000_FFFF, 16'h1234, 32'hDEAD_BEEF);
        check_val("b2b_gap", 32'(acc_cyc), 32'(eop_cyc + 1));
        wait_frames(5);
        compare_frame("b2b");
        exp_cnt = exp_cnt + 16'h2;
        check_val("b2b_pkt", 32'(pkt_count), 32'(exp_cnt));

        // Reset in the middle of a frame.
        offer(8'h88, 48'h0, 16'h0, 32'h1);
        t = 0;
        while (got_q.size() < 6 && t < 200) begin
            @(negedge clk);
            t++;
        end
        check_val("mid_bytes6", 32'(got_q.size()), 32'd6);
        @(posedge clk);
        #1;
        reset_n = 1'b0;
        #1;
        check_val("mid_out_valid", 32'(out_valid), 32'd0);
        check_val("mid_pkt_count", 32'(pkt_count), 32'd0);
        check_val("mid_in_ready", 32'(in_ready), 32'd1);
        exp_cnt = 16'h0;
        got_q.delete();
        exp_q.delete();
        @(posedge clk);
        #1;
        reset_n = 1'b1;
        build_exp(8'h88, 48'h0, 16'h0, 64'h1, 4, 1'b1);
        offer(8'h88, 48'h0, 16'h0, 32'h1);
        wait_frames(6);
        compare_frame("post_rst");
        exp_cnt = exp_cnt + 16'h1;
        check_val("post_rst_pkt", 32'(pkt_count), 32'(exp_cnt));

        // Randomized messages under random backpressure.
        rdy_mode = 2;
        for (int k = 0; k < 25; k++) begin
            c = rand_byte();
            for (int i = 0; i < 6; i++) a[8*i +: 8] = rand_byte();
            for (int i = 0; i < 2; i++) s[8*i +: 8] = rand_byte();
            for (int i = 0; i < 4; i++) d[8*i +: 8] = rand_byte();
            build_exp(c, a, s, {32'h0, d}, 4, 1'b1);
            offer(c, a, s, d);
            wait_frames(7 + k);
            compare_frame($sformatf("rnd%0d", k));
            exp_cnt = exp_cnt + 16'h1;
            check_val("rnd_pkt", 32'(pkt_count), 32'(exp_cnt));
            repeat ($urandom_range(0, 3)) @(posedge clk);
        end

        // Counter wrap from a preloaded 0xFFFF.
        rdy_mode = 0;
        @(posedge clk);
        #1;
        force dut.pkt_count = 16'hFFFF;
        #1;
        release dut.pkt_count;
        exp_cnt = 16'hFFFF;
        check_val("wrap_preload", 32'(pkt_count), 32'(exp_cnt));
        build_exp(8'h10, 48'h0, 16'h0, 64'h0, 4, 1'b1);
        offer(8'h10, 48'h0, 16'h0, 32'h0);
        wait_frames(32);
        compare_frame("wrap");
        exp_cnt = exp_cnt + 16'h1;
        check_val("wrap_pkt", 32'(pkt_count), 32'(exp_cnt));

        // DATA_BYTES=2, no checksum.
        @(posedge clk);
        #1;
        in_command2 = 8'h1B;
        in_valid2   = 1'b1;
        @(posedge clk);
        #1;
        in_valid2   = 1'b0;
        in_command2 = 8'($urandom);
        t = 0;
        while (frames2_done < 1 && t < 200) begin
            @(negedge clk);
            t++;
        end
        check_val("p2_done", 32'(frames2_done), 32'd1);
        @(posedge clk);
        #1;
        check_val("p2_len14", 32'(got2_q.size()), 32'd14);
        check_val("p2_pkt", 32'(pkt_count2), 32'd1);
        build_exp(8'h1B, 48'h0, 16'h0, 64'h0, 2, 1'b0);
        got_q = got2_q;
        got2_q.delete();
        compare_frame("p2");

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

    initial begin
        #3000000;
        $display("FAIL watchdog: simulation time limit reached, got %0d frames expected 32", frames_done);
        $fatal(1, "watchdog");
    end

endmodule

// File: doc/soundweb_stream_encoder.md
SOUNDWEB_STREAM_ENCODER -- requirements
Module: soundweb_stream_encoder

Interface
REQ-001 The block SHALL use one clock and an asynchronous, active-low reset: one clock; reset is asynchronous and active-low.
REQ-002 The block SHALL have parameter DATA_BYTES, default 4, giving the number of data bytes per message (legal range 1..8).
REQ-003 The block SHALL have parameter CSUM_EN, default 1; 1 inserts the XOR checksum byte, 0 omits it.
REQ-004 Port `clk`: input, 1 bit, system clock; all state is updated on its rising edge.
REQ-005 Port `reset_n`: input, 1 bit, asynchronous active-low reset.
REQ-006 Port `in_valid`: input, 1 bit, source offers a message.
REQ-007 Port `in_ready`: output, 1 bit, encoder can accept a message.
REQ-008 Port `in_command`: input, 8 bits, command byte.
REQ-009 Port `in_address`: input, 48 bits, address; byte 0 is [7:0] and byte 5 is [47:40].
REQ-010 Port `in_sv`: input, 16 bits, state-variable ID; byte 0 is [7:0].
REQ-011 Port `in_data`: input, 8*DATA_BYTES bits, data; byte 0 is [7:0].
REQ-012 Port `out_valid`: output, 1 bit, `out_byte` is valid.
REQ-013 Port `out_ready`: input, 1 bit, sink accepts `out_byte`.
REQ-014 Port `out_byte`: output, 8 bits, encoded stream byte.
REQ-015 Port `out_sop`: output, 1 bit, qualifies the STX byte.
REQ-016 Port `out_eop`: output, 1 bit, qualifies the ETX byte.
REQ-017 Port `busy`: output, 1 bit, a message is held or in transmission.
REQ-018 Port `pkt_count`: output, 16 bits, count of completed messages; wraps 0xFFFF->0x0000.

Function
REQ-019 A message SHALL be accepted only on a cycle with in_valid=1 and in_ready=1; all input fields are captured on that edge and are ignored afterwards.
REQ-020 in_ready SHALL be 1 only in state IDLE.
REQ-021 The FSM SHALL have states IDLE, STX, BODY, ESC, CSUM, CSUM_ESC, ETX.
  - IDLE->STX on accept.
  - STX->BODY on out handshake.
  - BODY->ESC when the current raw byte needs escaping.
  - BODY->CSUM after the last body byte (CSUM_EN=1), or BODY->ETX (CSUM_EN=0).
  - CSUM->CSUM_ESC when the checksum needs escaping.
  - ETX->IDLE on out handshake.
REQ-022 Raw body order SHALL be: command, address bytes 0..5, sv bytes 0..1, data bytes 0..DATA_BYTES-1, giving 9+DATA_BYTES raw bytes.
REQ-023 Each raw byte r in {0x02,0x03,0x06,0x15,0x1B} SHALL be emitted as two bytes, 0x1B then r+0x80; every other raw byte SHALL be emitted unchanged as one byte.
REQ-024 The checksum SHALL be the XOR of all raw (unescaped) body bytes, SHALL be accumulated incrementally, and SHALL itself be escaped per REQ-023.
REQ-025 The frame SHALL be 0x02, the escaped body, the escaped checksum, then 0x03; maximum length is 2+2*(10+DATA_BYTES) bytes.
REQ-026 out_valid SHALL rise on the cycle after accept with out_byte=0x02 and out_sop=1; the first STX therefore appears 1 cycle after accept.
REQ-027 One byte SHALL advance per cycle with out_valid=1 and out_ready=1; with out_ready held at 1, bytes are emitted on consecutive cycles.
REQ-028 While out_valid=1 and out_ready=0, out_byte, out_sop and out_eop SHALL be held stable and the FSM SHALL not advance.
REQ-029 out_valid SHALL never deassert before the byte it qualifies is handshaken.
REQ-030 out_sop and out_eop SHALL be 0 except on the STX and ETX bytes respectively.
REQ-031 pkt_count SHALL increment on the edge where ETX is handshaken.
REQ-032 busy SHALL be 1 in every state other than IDLE.
REQ-033 After ETX is handshaken, state SHALL be IDLE on the next cycle, so the minimum gap between consecutive accepts is 1 cycle with in_ready=1 in IDLE.
REQ-034 in_valid asserted while the block is busy SHALL have no effect; the source holds its message until in_ready=1.

Reset
REQ-035 When reset_n=0, the block SHALL asynchronously force state IDLE, in_ready=1, out_valid=0, out_byte=0x00, out_sop=0, out_eop=0, busy=0, pkt_count=0, checksum=0x00 and byte index=0.
REQ-036 Reset asserted mid-message SHALL abort the message with no ETX emitted and no pkt_count increment.
REQ-037 After reset_n rises, the first accept SHALL produce a complete new frame.

Verification
REQ-038 Nominal frame, DATA_BYTES=4, CSUM_EN=1, out_ready=1: cmd=0x88, addr=0, sv=0, data=0x00000001 -> 02 88 00 00 00 00 00 00 00 00 01 00 00 00 89 03 (16 bytes), sop on byte 1, eop on byte 16, pkt_count=1.
REQ-039 Escaped command and checksum: cmd=0x02, all other fields 0 -> 02 1B 82 00x12 1B 82 03 (18 bytes).
REQ-040 Backpressure: frame of REQ-038 with out_ready toggled 1,0,0,1,... -> identical byte sequence, out_byte stable during every stall, no byte lost or duplicated.
REQ-041 Parameter sweep: DATA_BYTES=2 with CSUM_EN=0, cmd=0x1B, others 0 -> 02 1B 9B 00x10 03 (14 bytes), no checksum byte.
REQ-042 Reset mid-frame: assert reset_n=0 after byte 6 -> out_valid=0 immediately and pkt_count=0; the next message yields a full frame starting with 0x02.
REQ-043 Back-to-back and wrap: two queued messages -> in_ready returns 1 cycle after ETX; preload 0xFFFF completions -> pkt_count wraps to 0x0000.
